// File: rtl/p2exp_pkg.sv
// rtl/p2exp_pkg.sv - shared types and the latch update helper for the P2 expander
package p2exp_pkg;

   typedef enum logic [1:0] {
      READ   = 2'b00,
      WRITE  = 2'b01,
      OP_OR  = 2'b10,
      OP_AND = 2'b11
   } bus_op_e;

   typedef logic [1:0] port_idx_t;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      RD_WAIT,
      RD_DRIVE,
      WR_WAIT
   } state_e;

   // New latch nibble for a write-class command; READ never commits.
   function automatic logic [3:0] apply_op(input bus_op_e op,
                                           input logic [3:0] cur,
                                           input logic [3:0] d);
      case (op)
         OP_OR:   return cur | d;
         OP_AND:  return cur & d;
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/p2exp_sync.sv
// rtl/p2exp_sync.sv - aligned prog_n/p2i synchronizer with edge detect
module p2exp_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       prog_n_i,
   input  logic [3:0] p2_i,
   output logic       prog_s_o,
   output logic       valid_o,
   output logic       fall_o,
   output logic       rise_o,
   output logic [3:0] p2_at_fall_o,
   output logic [3:0] p2_last_low_o
);

   // {prog_n, p2} travel together so every p2 sample lines up with its strobe sample
   logic [4:0]             chain_q [SYNC_STAGES];
   logic [4:0]             prev_q;
   logic [SYNC_STAGES:0]   fill_q;
   logic [4:0]             cur;

   // Shift chain plus one history stage; fill_q marks when prev_q holds a real pin sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) chain_q[i] <= 5'b10000;
         prev_q <= 5'b10000;
         fill_q <= '0;
      end else begin
         chain_q[0] <= {prog_n_i, p2_i};
         for (int i = 1; i < SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
         prev_q <= cur;
         fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign cur           = chain_q[SYNC_STAGES-1];
   assign prog_s_o      = cur[4];
   assign valid_o       = fill_q[SYNC_STAGES];
   // Edges are suppressed until the chain has flushed its reset contents
   assign fall_o        = valid_o &  prev_q[4] & ~cur[4];
   assign rise_o        = valid_o & ~prev_q[4] &  cur[4];
   // First sample with prog low carries the command
   assign p2_at_fall_o  = cur[3:0];
   // Sample from the last low cycle; the sample taken at rise may already be past data hold
   assign p2_last_low_o = prev_q[3:0];

endmodule

// File: rtl/p2_expander_resp.sv
// rtl/p2_expander_resp.sv - 8243-style P2 bus I/O expander responder
module p2_expander_resp
   import p2exp_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter int          OE_DELAY    = 2,
   parameter logic [15:0] RST_PORTS   = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        prog_n,
   input  logic [3:0]  p2i,
   output logic [3:0]  p2o,
   output logic        p2_oe,
   input  logic [15:0] pin_i,
   output logic [15:0] pout_o,
   output logic [3:0]  pdir_o,
   output logic [3:0]  wr_pulse,
   output logic [3:0]  rd_pulse
);

   logic       prog_s, sync_valid, fall, rise;
   logic [3:0] p2_at_fall, p2_last_low;

   p2exp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk           (clk),
      .rst           (rst),
      .prog_n_i      (prog_n),
      .p2_i          (p2i),
      .prog_s_o      (prog_s),
      .valid_o       (sync_valid),
      .fall_o        (fall),
      .rise_o        (rise),
      .p2_at_fall_o  (p2_at_fall),
      .p2_last_low_o (p2_last_low)
   );

   state_e     state_q;
   bus_op_e    op_q;
   port_idx_t  addr_q;
   logic [7:0] cnt_q;
   logic       started_q;
   logic [3:0] p2o_q;
   logic       p2_oe_q;
   logic [15:0] pout_q;
   logic [3:0] pdir_q, wr_pulse_q, rd_pulse_q;

   bus_op_e    cmd_op_d;
   port_idx_t  cmd_addr_d;
   logic [3:0] wr_nibble_d;

   assign cmd_op_d    = bus_op_e'(p2_at_fall[3:2]);
   assign cmd_addr_d  = p2_at_fall[1:0];
   assign wr_nibble_d = apply_op(op_q, pout_q[{addr_q, 2'b00} +: 4], p2_last_low);

   // Bus cycle FSM with registered bus drive, latches and strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= READ;
         addr_q     <= '0;
         cnt_q      <= '0;
         started_q  <= 1'b0;
         p2o_q      <= '0;
         p2_oe_q    <= 1'b0;
         pout_q     <= RST_PORTS;
         pdir_q     <= '0;
         wr_pulse_q <= '0;
         rd_pulse_q <= '0;
      end else begin
         wr_pulse_q <= '0;
         rd_pulse_q <= '0;
         started_q  <= started_q | sync_valid;
         case (state_q)
            IDLE: begin
               if (fall) begin
                  op_q   <= cmd_op_d;
                  addr_q <= cmd_addr_d;
                  if (cmd_op_d == READ) begin
                     // Read data is frozen at decode so the bus value cannot tear
                     p2o_q                <= pin_i[{cmd_addr_d, 2'b00} +: 4];
                     pdir_q[cmd_addr_d]   <= 1'b0;
                     cnt_q                <= '0;
                     state_q              <= RD_WAIT;
                  end else begin
                     state_q <= WR_WAIT;
                  end
               end else if (!started_q && sync_valid && !prog_s) begin
                  // Came out of reset inside a bus cycle: sit it out
                  state_q <= ARM;
               end
            end
            RD_WAIT: begin
               if (rise) begin
                  state_q <= IDLE;
               end else if (cnt_q == 8'(OE_DELAY - 1)) begin
                  p2_oe_q <= 1'b1;
                  state_q <= RD_DRIVE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            RD_DRIVE: begin
               if (rise) begin
                  p2_oe_q            <= 1'b0;
                  rd_pulse_q[addr_q] <= 1'b1;
                  state_q            <= IDLE;
               end
            end
            WR_WAIT: begin
               if (rise) begin
                  pout_q[{addr_q, 2'b00} +: 4] <= wr_nibble_d;
                  pdir_q[addr_q]               <= 1'b1;
                  wr_pulse_q[addr_q]           <= 1'b1;
                  state_q                      <= IDLE;
               end
            end
            ARM: begin
               if (rise) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign p2o      = p2o_q;
   assign p2_oe    = p2_oe_q;
   assign pout_o   = pout_q;
   assign pdir_o   = pdir_q;
   assign wr_pulse = wr_pulse_q;
   assign rd_pulse = rd_pulse_q;

endmodule

// File: tb/tb_p2_expander_resp.sv
// tb/tb_p2_expander_resp.sv - scoreboard bench for p2_expander_resp
module tb_p2_expander_resp;
   import p2exp_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        prog_n = 1'b1;
   logic [3:0]  p2i = 4'h0;
   logic [15:0] pin_i = 16'h0000;
   logic [3:0]  p2o;
   logic        p2_oe;
   logic [15:0] pout_o;
   logic [3:0]  pdir_o, wr_pulse, rd_pulse;

   p2_expander_resp dut (
      .clk      (clk),
      .rst      (rst),
      .prog_n   (prog_n),
      .p2i      (p2i),
      .p2o      (p2o),
      .p2_oe    (p2_oe),
      .pin_i    (pin_i),
      .pout_o   (pout_o),
      .pdir_o   (pdir_o),
      .wr_pulse (wr_pulse),
      .rd_pulse (rd_pulse)
   );

   always #20 clk = ~clk;

   typedef struct packed {
      logic       is_rd;
      logic [1:0] addr;
      logic [3:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   rd2_cnt = 0;
   logic oe_seen = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // MCU read cycle; pin nibble is flipped mid-cycle to prove capture at decode
   task automatic do_read(input logic [1:0] addr, input logic [3:0] exp, input logic mid_chk);
      sb_q.push_back({1'b1, addr, exp});
      p2i = {READ, addr};
      #5 prog_n = 1'b0;
      #60 p2i = 4'h6;
      #300 pin_i[{addr, 2'b00} +: 4] = ~exp;
      #335;
      if (mid_chk) begin
         chk("rd_oe_mid", p2_oe, 1);
         chk("rd_p2o_mid", p2o, exp);
      end
      prog_n = 1'b1;
      #20 p2i = 4'h9;
      #980;
   endtask

   // MCU write-class cycle: command held 60 ns, data held 20 ns past rise
   task automatic do_write(input bus_op_e op, input logic [1:0] addr,
                           input logic [3:0] data, input logic [3:0] exp);
      sb_q.push_back({1'b0, addr, exp});
      p2i = {op, addr};
      #5 prog_n = 1'b0;
      #60 p2i = data;
      #635 prog_n = 1'b1;
      #20 p2i = ~data;
      #980;
   endtask

   // Monitor: every strobe must match the next queued expectation
   initial begin
      exp_t       e;
      logic [3:0] one;
      forever begin
         @(negedge clk);
         if (rst) begin
            oe_seen = 1'b0;
         end else begin
            if (p2_oe) oe_seen = 1'b1;
            if ((rd_pulse | wr_pulse) != 4'h0) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_pulse", {rd_pulse, wr_pulse}, 0);
               end else begin
                  e   = sb_q.pop_front();
                  one = 4'b0001 << e.addr;
                  if (e.is_rd) begin
                     chk("rd_pulses", {rd_pulse, wr_pulse}, {one, 4'h0});
                     chk("rd_data", p2o, e.data);
                     chk("rd_oe_seen", oe_seen, 1);
                     chk("rd_pdir", pdir_o[e.addr], 0);
                     oe_seen = 1'b0;
                     if (e.addr == 2'd2) rd2_cnt++;
                  end else begin
                     chk("wr_pulses", {rd_pulse, wr_pulse}, {4'h0, one});
                     chk("wr_latch", pout_o[{e.addr, 2'b00} +: 4], e.data);
                     chk("wr_pdir", pdir_o[e.addr], 1);
                  end
               end
            end
         end
      end
   end

   initial begin
      logic [3:0] poll_vals [8];
      poll_vals = '{4'h3, 4'h7, 4'h0, 4'hF, 4'h5, 4'hA, 4'hC, 4'h9};

      #107;
      chk("rst_p2o", p2o, 0);
      chk("rst_p2_oe", p2_oe, 0);
      chk("rst_pout", pout_o, 16'hFFFF);
      chk("rst_pdir", pdir_o, 0);
      chk("rst_pulses", {rd_pulse, wr_pulse}, 0);
      rst = 1'b0;
      #200;

      pin_i = 16'h0A00;
      do_read(2'd2, 4'hA, 1'b1);
      chk("rd_oe_after_rise", p2_oe, 0);
      chk("rd_pdir2_input", pdir_o[2], 0);

      do_write(WRITE,  2'd3, 4'b1110, 4'hE);
      do_write(OP_AND, 2'd3, 4'b1101, 4'hC);
      do_write(OP_OR,  2'd3, 4'b0011, 4'hF);
      do_write(WRITE,  2'd0, 4'h4,    4'h4);

      // Reset in the middle of a driven read, released with prog_n still low
      p2i = {READ, 2'd2};
      #5 prog_n = 1'b0;
      #300 chk("abort_oe_before", p2_oe, 1);
      rst = 1'b1;
      #1;
      chk("abort_oe_async", p2_oe, 0);
      chk("abort_latches", pout_o, 16'hFFFF);
      #99 rst = 1'b0;
      #400 prog_n = 1'b1;
      #20 p2i = 4'h9;
      #980;

      do_write(WRITE, 2'd1, 4'h5, 4'h5);

      for (int i = 0; i < 8; i++) begin
         pin_i[11:8] = poll_vals[i];
         do_read(2'd2, poll_vals[i], 1'b0);
      end

      #2000;
      chk("sb_empty", sb_q.size(), 0);
      chk("rd2_count", rd2_cnt, 9);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
